// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C master among N_REQ requesters,
// issuing single-byte transactions and supervising each with a timeout.
module i2c_txn_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk_400,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_rw,
  input  logic [7*N_REQ-1:0]       req_addr,
  input  logic [8*N_REQ-1:0]       req_wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic                     resp_valid,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [7:0]               resp_rdata,
  output logic                     resp_err,
  output logic                     resp_timeout,
  output logic                     arb_busy,
  output logic                     m_start_txn,
  output logic                     m_rw,
  output logic [6:0]               m_sub_addr,
  output logic [7:0]               m_data_in,
  output logic                     m_next_byte,
  input  logic                     m_busy,
  input  logic                     m_done,
  input  logic                     m_ack_error,
  input  logic [7:0]               m_data_out
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              start_q, start_d;
  logic              m_rw_q, m_rw_d;
  logic [6:0]        m_addr_q, m_addr_d;
  logic [7:0]        m_wdata_q, m_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [7:0]        resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              resp_to_q, resp_to_d;
  logic              busy_q, busy_d;

  logic              win_found_s;
  logic [ID_W-1:0]   win_id_s;
  logic [ID_W-1:0]   cand_s;
  logic              grant_s;
  logic              timeout_s;
  logic [6:0]        addr_arr_s  [N_REQ];
  logic [7:0]        wdata_arr_s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr_s[g]  = req_addr[7*g +: 7];
    assign wdata_arr_s[g] = req_wdata[8*g +: 8];
  end

  // Round-robin search, starting just after the last served requester.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    cand_s      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = ID_W'((int'(last_id_q) + k) % N_REQ);
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign timeout_s = (cnt_q == CNT_LAST);

  // State register and all registered outputs.
  always_ff @(posedge clk_400 or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_id_q     <= '0;
      last_id_q    <= ID_W'(N_REQ - 1);
      cnt_q        <= '0;
      gnt_q        <= '0;
      start_q      <= 1'b0;
      m_rw_q       <= 1'b0;
      m_addr_q     <= 7'h00;
      m_wdata_q    <= 8'h00;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_rdata_q <= 8'h00;
      resp_err_q   <= 1'b0;
      resp_to_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      last_id_q    <= last_id_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      start_q      <= start_d;
      m_rw_q       <= m_rw_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      resp_to_q    <= resp_to_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic; a busy master blocks arbitration in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s && !m_busy) state_d = S_LAUNCH;
        else                        state_d = S_IDLE;
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (m_done || timeout_s) state_d = S_RESP;
        else                     state_d = S_WAIT;
      end
      S_RESP: state_d = S_DRAIN;
      S_DRAIN: begin
        if (!m_done && !m_busy) state_d = S_IDLE;
        else                    state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; m_done beats a simultaneous timeout.
  always_comb begin
    grant_s      = (state_q == S_IDLE) && (state_d == S_LAUNCH);
    gnt_d        = '0;
    start_d      = grant_s;
    cur_id_d     = cur_id_q;
    m_rw_d       = m_rw_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    last_id_d    = last_id_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    resp_to_d    = resp_to_q;
    busy_d       = (state_d != S_IDLE);
    if (grant_s) begin
      gnt_d     = {{(N_REQ-1){1'b0}}, 1'b1} << win_id_s;
      cur_id_d  = win_id_s;
      m_rw_d    = req_rw[win_id_s];
      m_addr_d  = addr_arr_s[win_id_s];
      m_wdata_d = wdata_arr_s[win_id_s];
    end else begin
      gnt_d = '0;
    end
    case (state_q)
      S_LAUNCH: cnt_d = '0;
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (m_done) begin
          resp_valid_d = 1'b1;
          resp_id_d    = cur_id_q;
          resp_rdata_d = m_rw_q ? m_data_out : 8'h00;
          resp_err_d   = m_ack_error;
          resp_to_d    = 1'b0;
        end else if (timeout_s) begin
          resp_valid_d = 1'b1;
          resp_id_d    = cur_id_q;
          resp_rdata_d = 8'h00;
          resp_err_d   = 1'b1;
          resp_to_d    = 1'b1;
        end else begin
          resp_valid_d = 1'b0;
        end
      end
      S_RESP:  last_id_d = cur_id_q;
      default: cnt_d = cnt_q;
    endcase
  end

  assign gnt          = gnt_q;
  assign m_start_txn  = start_q;
  assign m_rw         = m_rw_q;
  assign m_sub_addr   = m_addr_q;
  assign m_data_in    = m_wdata_q;
  assign m_next_byte  = 1'b0;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign resp_timeout = resp_to_q;
  assign arb_busy     = busy_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: vector table plus scoreboard queues,
// with a small behavioural I2C master/subordinate model.
module tb_i2c_txn_arbiter;
  localparam int N  = 4;
  localparam int TO = 32;

  logic clk_400 = 1'b0;
  always #5 clk_400 = ~clk_400;

  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_rw = '0;
  logic [27:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [N-1:0] gnt;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic [7:0]   resp_rdata;
  logic         resp_err, resp_timeout, arb_busy;
  logic         m_start_txn, m_rw, m_next_byte;
  logic [6:0]   m_sub_addr;
  logic [7:0]   m_data_in;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_ack_error = 1'b0;
  logic [7:0]   m_data_out = 8'h00;

  logic [6:0] a_arr [N];
  logic [7:0] w_arr [N];
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[7*g +: 7]  = a_arr[g];
    assign req_wdata[8*g +: 8] = w_arr[g];
  end

  i2c_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk_400(clk_400), .rst(rst), .req(req), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_timeout(resp_timeout), .arb_busy(arb_busy),
    .m_start_txn(m_start_txn), .m_rw(m_rw), .m_sub_addr(m_sub_addr),
    .m_data_in(m_data_in), .m_next_byte(m_next_byte), .m_busy(m_busy),
    .m_done(m_done), .m_ack_error(m_ack_error), .m_data_out(m_data_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_400) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Master + subordinate model: acks 0x01/0x10/0x30, NACKs everything else.
  logic [7:0] mem [128];
  int         mm_cnt = 0;
  logic       mm_rw = 1'b0, mm_hang = 1'b0, hang_mode = 1'b0;
  logic [6:0] mm_addr = 7'h00;
  logic [7:0] mm_wd = 8'h00;

  function automatic logic sub_ack(input logic [6:0] a);
    return (a == 7'h01) || (a == 7'h10) || (a == 7'h30);
  endfunction

  always @(posedge clk_400) begin
    if (m_start_txn) begin
      m_busy  <= 1'b1;
      mm_cnt  <= hang_mode ? 50 : 2;
      mm_hang <= hang_mode;
      mm_rw   <= m_rw;
      mm_addr <= m_sub_addr;
      mm_wd   <= m_data_in;
    end else if (mm_cnt != 0) begin
      mm_cnt <= mm_cnt - 1;
      if (mm_cnt == 1) begin
        if (mm_hang) begin
          m_busy <= 1'b0;
        end else begin
          m_done      <= 1'b1;
          m_ack_error <= !sub_ack(mm_addr);
          m_data_out  <= mm_rw ? (sub_ack(mm_addr) ? mem[mm_addr] : 8'hFF) : 8'hEE;
          if (!mm_rw && sub_ack(mm_addr)) mem[mm_addr] <= mm_wd;
        end
      end
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end
  end

  typedef struct {
    logic [1:0] id;
    logic [7:0] rdata;
    logic       err;
    logic       to;
  } exp_t;

  typedef struct {
    logic [1:0] id;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    logic       to;
    logic       hang;
  } vec_t;

  exp_t       exp_q [$];
  logic [1:0] gnt_q [$];
  int         done_cyc = 0, launch_cyc = 0;
  logic       prev_busy = 1'b0;

  // Monitor: grant order/shape, response contents and response latency.
  always @(negedge clk_400) begin
    if (!rst) begin
      if (m_done) done_cyc = cyc;
      if (m_start_txn) launch_cyc = cyc;
      if (gnt != 4'b0000 || m_start_txn) begin
        logic [1:0] eg;
        logic [3:0] oh;
        check("start_with_gnt", 32'(m_start_txn), 32'(|gnt));
        check("gnt_onehot", $countones(gnt), 1);
        check("no_gnt_while_busy", 32'(prev_busy), 0);
        check("gnt_expected", gnt_q.size() > 0 ? 1 : 0, 1);
        eg = (gnt_q.size() > 0) ? gnt_q.pop_front() : 2'd0;
        oh = 4'b0001 << eg;
        check("gnt_order", 32'(gnt), 32'(oh));
      end
      if (resp_valid) begin
        exp_t e;
        check("resp_expected", exp_q.size() > 0 ? 1 : 0, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '{2'd0, 8'h00, 1'b0, 1'b0};
        check("resp_id", 32'(resp_id), 32'(e.id));
        check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("resp_timeout", 32'(resp_timeout), 32'(e.to));
        if (e.to) check("timeout_latency", cyc - launch_cyc, TO + 1);
        else      check("done_latency", cyc - done_cyc, 1);
      end
      prev_busy = m_busy;
    end
  end

  task automatic wait_gnt(output logic [1:0] g);
    logic seen;
    seen = 1'b0;
    g = 2'd0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_400);
      if (gnt != 4'b0000) begin
        seen = 1'b1;
        for (int b = 0; b < N; b++) if (gnt[b]) g = 2'(b);
      end
    end
    check("gnt_seen", 32'(seen), 1);
  endtask

  task automatic wait_resp();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_400);
      if (resp_valid) seen = 1'b1;
    end
    check("resp_seen", 32'(seen), 1);
  endtask

  task automatic wait_idle();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_400);
      if (!arb_busy) seen = 1'b1;
    end
    check("idle_seen", 32'(seen), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({gnt, resp_valid, resp_id, resp_err, resp_timeout,
                              arb_busy, m_start_txn, m_rw, m_next_byte}), 0);
    check({tag, "_data"}, 32'({resp_rdata, m_sub_addr, m_data_in}), 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] g;
    exp_t e;
    @(negedge clk_400);
    hang_mode   = v.hang;
    req_rw[v.id] = v.rw;
    a_arr[v.id] = v.addr;
    w_arr[v.id] = v.wdata;
    req[v.id]   = 1'b1;
    e = '{v.id, v.rdata, v.err, v.to};
    gnt_q.push_back(v.id);
    exp_q.push_back(e);
    wait_gnt(g);
    check("gnt_id", 32'(g), 32'(v.id));
    check("m_sub_addr", 32'(m_sub_addr), 32'(v.addr));
    check("m_rw", 32'(m_rw), 32'(v.rw));
    if (!v.rw) check("m_data_in", 32'(m_data_in), 32'(v.wdata));
    check("m_next_byte", 32'(m_next_byte), 0);
    req[v.id] = 1'b0;
    wait_resp();
    hang_mode = 1'b0;
    wait_idle();
    check("resp_hold", 32'(resp_rdata), 32'(v.rdata));
    if (!v.rw && !v.err) check("sub_mem", 32'(mem[v.addr]), 32'(v.wdata));
  endtask

  vec_t vecs [9];

  initial begin
    logic [1:0] g;
    logic [1:0] order [5];
    vecs[0] = '{2'd2, 1'b0, 7'h01, 8'hAB, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'd1, 1'b0, 7'h01, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'd0, 1'b1, 7'h01, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'd3, 1'b0, 7'h22, 8'h11, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'd2, 1'b1, 7'h22, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{2'd0, 1'b0, 7'h30, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'd3, 1'b1, 7'h30, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'd1, 1'b1, 7'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{2'd2, 1'b1, 7'h01, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < N; i++) begin
      a_arr[i] = 7'h00;
      w_arr[i] = 8'h00;
    end

    #1 rst = 1'b1;
    repeat (3) @(negedge clk_400);
    check_all_zero("reset");
    rst = 1'b0;

    // Contention from reset: all four write, each re-requests after its response.
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    @(negedge clk_400);
    for (int i = 0; i < N; i++) begin
      a_arr[i] = 7'h10;
      w_arr[i] = 8'h50 + 8'(i);
    end
    req_rw = 4'b0000;
    for (int t = 0; t < 5; t++) begin
      gnt_q.push_back(order[t]);
      exp_q.push_back('{order[t], 8'h00, 1'b0, 1'b0});
    end
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_gnt(g);
      check("cont_gnt", 32'(g), 32'(order[t]));
      check("cont_data_in", 32'(m_data_in), 32'(8'h50 + 8'(order[t])));
      req[g] = 1'b0;
      wait_resp();
      if (t < 4) req[g] = 1'b1;
      else       req = 4'b0000;
    end
    wait_idle();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset in the middle of WAIT during a read from requester 3.
    @(negedge clk_400);
    req_rw[3] = 1'b1;
    a_arr[3]  = 7'h01;
    req[3]    = 1'b1;
    gnt_q.push_back(2'd3);
    wait_gnt(g);
    req[3] = 1'b0;
    repeat (2) @(negedge clk_400);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_wait_reset");
    @(negedge clk_400);
    #2 rst = 1'b0;

    @(negedge clk_400);
    req_rw[0] = 1'b1; a_arr[0] = 7'h01;
    req_rw[1] = 1'b1; a_arr[1] = 7'h01;
    gnt_q.push_back(2'd0);
    gnt_q.push_back(2'd1);
    exp_q.push_back('{2'd0, 8'hC3, 1'b0, 1'b0});
    exp_q.push_back('{2'd1, 8'hC3, 1'b0, 1'b0});
    req[0] = 1'b1;
    req[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      wait_gnt(g);
      check("post_reset_gnt", 32'(g), t);
      req[g] = 1'b0;
      wait_resp();
    end
    wait_idle();

    repeat (3) @(negedge clk_400);
    check("gnt_q_drained", gnt_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
